// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared state codes and widths for the instruction-memory loader
package im_loader_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int CK_W = 32;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
endpackage

// File: rtl/im_loader_cksum.sv
// ld_cksum: running 32-bit modular sum of loaded words
// Ports: clk, rst (sync, active high), clear (restart sum), add_en (accumulate data), data in, sum out.
module ld_cksum
  import im_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            add_en,
  input  logic [CK_W-1:0] data,
  output logic [CK_W-1:0] sum
);
  logic [CK_W-1:0] sum_q, sum_d;
  always_comb sum_d = clear ? '0 : add_en ? sum_q + data : sum_q;
  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else sum_q <= sum_d;
  end
  assign sum = sum_q;
endmodule

// File: rtl/im_loader.sv
// im_loader: streams a program into instruction memory, then releases the core from reset
// Ports: start/len_m1 request a load of len_m1+1 words; in_valid/in_ready/in_data carry the words;
// im_we/im_addr/im_din write the memory; cpu_rst/done/err report the phase.
// Build option: IM_LOADER_CHECKSUM_EN appends a checksum word compared against the sum of the data words.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len_m1,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_din,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, len_q, len_d, addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic we_q, we_d;
  logic hs, fire;
  assign hs = in_valid && in_ready;
  assign fire = start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);
`ifdef IM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_TAIL = S_CHECK;
  logic [CK_W-1:0] sum;
  ld_cksum u_cksum (
    .clk    (clk),
    .rst    (rst),
    .clear  (fire),
    .add_en (hs && state_q == S_LOAD),
    .data   (in_data),
    .sum    (sum)
  );
  assign in_ready = state_q == S_LOAD || state_q == S_CHECK;
  assign err = state_q == S_ERR;
`else
  localparam logic [2:0] S_TAIL = S_DRAIN;
  assign in_ready = state_q == S_LOAD;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    addr_d = addr_q;
    din_d = din_q;
    we_d = 1'b0;
    if (fire) begin
      state_d = S_LOAD;
      len_d = len_m1;
      cnt_d = '0;
      addr_d = '0;
    end
    if (state_q == S_LOAD && hs) begin
      we_d = 1'b1;
      addr_d = cnt_q;
      din_d = in_data;
      cnt_d = cnt_q + ADDR_W'(1);
      state_d = cnt_q == len_q ? S_TAIL : S_LOAD;
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (state_q == S_CHECK && hs) state_d = in_data == sum ? S_DRAIN : S_ERR;
`endif
    if (state_q == S_DRAIN) state_d = S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
    end
  end
  assign im_we = we_q;
  assign im_addr = addr_q;
  assign im_din = din_q;
  assign cpu_rst = state_q != S_RUN;
  assign done = state_q == S_RUN;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized and directed checks of im_loader against a phase-level reference model
module tb_im_loader;
  localparam int AW = 10;
  localparam int P_IDLE = 0, P_LOAD = 1, P_CHK = 2, P_TAIL = 3, P_RUN = 4, P_ERR = 5;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] len_m1 = '0;
  logic [31:0] in_data = '0;
  logic in_ready, im_we, cpu_rst, done, err;
  logic [AW-1:0] im_addr;
  logic [31:0] im_din;

  im_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len_m1(len_m1), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_din(im_din),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ph = P_IDLE, n = 0, len = 0, we_cnt = 0;
  bit armed = 1'b0;
  logic [31:0] sum = '0;
  logic e_we = 1'b0;
  logic [AW-1:0] e_addr = '0, last_addr = '0;
  logic [31:0] e_din = '0;
  logic [31:0] mem_exp [1024];
  logic [31:0] dut_mem [1024];
  logic [31:0] w [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task step();
    if (rst) begin
      armed = 1'b1; ph = P_IDLE; n = 0; sum = '0; e_we = 1'b0; e_addr = '0; e_din = '0;
    end else begin
      e_we = 1'b0;
      case (ph)
        P_IDLE, P_RUN, P_ERR: if (start) begin
          ph = P_LOAD; len = int'(len_m1); n = 0; sum = '0; e_addr = '0;
        end
        P_LOAD: if (in_valid) begin
          e_we = 1'b1; e_addr = AW'(n); e_din = in_data; mem_exp[n] = in_data;
          sum = sum + in_data; n++;
          if (n > len) ph = CK ? P_CHK : P_TAIL;
        end
        P_CHK: if (in_valid) ph = (in_data == sum) ? P_TAIL : P_ERR;
        P_TAIL: ph = P_RUN;
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    step();
  end

  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(ph == P_LOAD || ph == P_CHK));
      chk("im_we", 32'(im_we), 32'(e_we));
      chk("im_addr", 32'(im_addr), 32'(e_addr));
      chk("im_din", im_din, e_din);
      chk("cpu_rst", 32'(cpu_rst), 32'(ph != P_RUN));
      chk("done", 32'(done), 32'(ph == P_RUN));
      chk("err", 32'(err), 32'(ph == P_ERR));
      if (im_we === 1'b1) begin
        dut_mem[im_addr] = im_din;
        we_cnt++;
        last_addr = im_addr;
      end
    end
  end

  task automatic do_start(input int l);
    start = 1'b1;
    len_m1 = AW'(l);
    @(negedge clk);
    start = 1'b0;
    len_m1 = AW'($urandom);
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int t = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data = $urandom;
      start = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    in_data = $urandom;
  endtask

  task automatic load(input int l, input int gmax, input bit bad);
    logic [31:0] s = '0;
    do_start(l);
    for (int i = 0; i <= l; i++) begin
      send(w[i], $urandom_range(0, gmax));
      s = s + w[i];
    end
    if (CK) send(s + 32'(bad), $urandom_range(0, gmax));
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base, l, nbad;
    for (int i = 0; i < 1024; i++) begin
      mem_exp[i] = '0;
      dut_mem[i] = '0;
    end
    w[0] = 32'h20080005; w[1] = 32'h20090007; w[2] = 32'h01095020; w[3] = 32'h08000000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_im_we", 32'(im_we), 0);
    chk("rst_im_addr", 32'(im_addr), 0);
    chk("rst_im_din", im_din, 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);

    base = we_cnt;
    load(3, 0, 1'b0);
`ifndef IM_LOADER_CHECKSUM_EN
    chk("last_we", 32'(im_we), 1);
    chk("last_addr", 32'(im_addr), 3);
    chk("last_din", im_din, 32'h08000000);
`endif
    chk("cpu_rst_drain", 32'(cpu_rst), 1);
    @(negedge clk);
    chk("cpu_rst_run", 32'(cpu_rst), 0);
    chk("done_run", 32'(done), 1);
    chk("we_count_4", 32'(we_cnt - base), 4);
    chk("mem0", dut_mem[0], 32'h20080005);
    chk("mem1", dut_mem[1], 32'h20090007);
    chk("mem2", dut_mem[2], 32'h01095020);
    chk("mem3", dut_mem[3], 32'h08000000);

    base = we_cnt;
    load(3, 3, 1'b0);
    settle();
    chk("gap_we_count", 32'(we_cnt - base), 4);
    chk("gap_done", 32'(done), 1);
    chk("gap_mem3", dut_mem[3], 32'h08000000);

    w[0] = 32'hDEADBEEF;
    base = we_cnt;
    do_start(0);
    chk("restart_cpu_rst", 32'(cpu_rst), 1);
    chk("restart_ready", 32'(in_ready), 1);
    send(w[0], 0);
    if (CK) send(32'hDEADBEEF, 0);
    settle();
    chk("single_we", 32'(we_cnt - base), 1);
    chk("single_addr", 32'(last_addr), 0);
    chk("single_data", dut_mem[0], 32'hDEADBEEF);
    chk("single_done", 32'(done), 1);

    for (int i = 0; i < 8; i++) w[i] = $urandom;
    base = we_cnt;
    do_start(7);
    send(w[0], 0);
    send(w[1], 1);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("abort_we_count", 32'(we_cnt - base), 2);
    chk("abort_cpu_rst", 32'(cpu_rst), 1);
    chk("abort_done", 32'(done), 0);
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    base = we_cnt;
    load(3, 2, 1'b0);
    settle();
    chk("reload_we_count", 32'(we_cnt - base), 4);
    chk("reload_mem0", dut_mem[0], w[0]);

    repeat (6) begin
      l = $urandom_range(0, 20);
      for (int i = 0; i <= l; i++) w[i] = $urandom;
      base = we_cnt;
      load(l, 3, $urandom_range(0, 3) == 0);
      settle();
      chk("rand_we_count", 32'(we_cnt - base), 32'(l + 1));
    end

`ifdef IM_LOADER_CHECKSUM_EN
    w[0] = 32'h1; w[1] = 32'h2;
    load(1, 0, 1'b0);
    settle();
    chk("ck_good_done", 32'(done), 1);
    chk("ck_good_err", 32'(err), 0);
    load(1, 0, 1'b1);
    settle();
    chk("ck_bad_err", 32'(err), 1);
    chk("ck_bad_cpu_rst", 32'(cpu_rst), 1);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("ck_bad_hold", 32'(err), 1);
    load(1, 0, 1'b0);
    settle();
    chk("ck_recover_done", 32'(done), 1);
    chk("ck_recover_err", 32'(err), 0);
`endif

    for (int i = 0; i < 1024; i++) w[i] = $urandom;
    base = we_cnt;
    load(1023, 0, 1'b0);
    settle();
    in_valid = 1'b1;
    in_data = $urandom;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("full_we_count", 32'(we_cnt - base), 1024);
    chk("full_last_addr", 32'(last_addr), 1023);
    chk("full_mem_top", dut_mem[1023], w[1023]);

    nbad = 0;
    for (int i = 0; i < 1024; i++) if (dut_mem[i] !== mem_exp[i]) nbad++;
    chk("mem_image", 32'(nbad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter ADDR_W, default 10, sets instruction-memory word-address width (1024 words).
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  request a (re)load; sampled only in IDLE, RUN, ERR.
REQ-005 Port len_m1  input  ADDR_W  word count minus one; sampled on the accepted start.
REQ-006 Port in_valid  input  1  upstream word valid.
REQ-007 Port in_data  input  32  upstream instruction word.
REQ-008 Port in_ready  output  1  loader accepts a word; transfer occurs when in_valid && in_ready on a clock edge.
REQ-009 Port im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port im_addr  output  ADDR_W  word address of the write.
REQ-011 Port im_din  output  32  data for the write.
REQ-012 Port cpu_rst  output  1  held-reset to the processor core; high whenever not in RUN.
REQ-013 Port done  output  1  high in RUN.
REQ-014 Port err  output  1  high in ERR (checksum builds only; tied 0 otherwise).

Function
REQ-015 States: IDLE, LOAD, CHECK (checksum builds only), DRAIN, RUN, ERR.
REQ-016 IDLE/RUN/ERR + start -> LOAD; latch len_m1; clear word counter and address to 0.
REQ-017 LOAD: in_ready=1; every other state: in_ready=0; in_valid while in_ready=0 ignored, no write.
REQ-018 Each accepted word in cycle N: im_we=1, im_addr=counter, im_din=in_data, all registered, visible in cycle N+1; counter increments by 1.
REQ-019 Accepting word with counter==len_m1 ends data phase: -> CHECK (macro defined) or DRAIN (macro undefined).
REQ-020 Back-to-back handshakes every cycle SHALL be sustained; im_we may be high on consecutive cycles.
REQ-021 DRAIN lasts exactly one cycle (final im_we visible) then -> RUN; cpu_rst low from first RUN cycle, i.e. two cycles after last data handshake.
REQ-022 len_m1 = 2**ADDR_W-1 loads full memory; address never wraps; no write beyond len_m1.
REQ-023 start during LOAD/CHECK/DRAIN ignored.
REQ-024 start in RUN: cpu_rst reasserts the next cycle; memory contents beyond new length untouched.
REQ-025 im_we is 0 in every state except the cycle following an accepted data word.

Reset
REQ-026 rst (any state, including mid-LOAD) -> IDLE next edge; outputs: in_ready=0, im_we=0, im_addr=0, im_din=0, cpu_rst=1, done=0, err=0; counter, checksum cleared; no write issued in the cycle following rst.

Configuration
REQ-027 Macro IM_LOADER_CHECKSUM_EN.
REQ-028 Defined: 32-bit sum mod 2**32 of all data words accumulated; CHECK has in_ready=1, accepts one extra word (not written); equal -> DRAIN, unequal -> ERR (err=1, cpu_rst=1, done=0) until start or rst.
REQ-029 Undefined: no CHECK/ERR states, no accumulator, err constant 0, length-only framing.

Structure
REQ-030 Shared package im_loader_pkg: state enumeration, default ADDR_W constant, checksum width constant.
REQ-031 One sub-module ld_cksum (clear, add-enable, 32-bit data in, 32-bit sum out), instantiated only under IM_LOADER_CHECKSUM_EN.

Verification
REQ-032 rst, start, len_m1=3, words 0x20080005,0x20090007,0x01095020,0x08000000 every cycle -> im_we on 4 consecutive cycles, addr 0..3, cpu_rst falls 2 cycles after 4th handshake, done=1.
REQ-033 Same load with in_valid gaps of 0-3 random cycles -> identical write sequence, no extra im_we.
REQ-034 rst asserted after 2nd word of len_m1=7 -> IDLE, cpu_rst=1, no further im_we; fresh start reloads from addr 0.
REQ-035 Checksum build, len_m1=1, words 0x1,0x2, checksum 0x3 -> RUN; checksum 0x4 -> err=1, cpu_rst stays 1, second start recovers.
REQ-036 len_m1=1023 -> last write at addr 1023, 1024 im_we pulses total, 1025th in_valid not accepted.
REQ-037 start in RUN, len_m1=0, word 0xDEADBEEF -> cpu_rst high next cycle, single write addr 0, RUN re-entered.
